stopwatch_display_scan: RTL and testbench
=========================================

// Module: stopwatch_display_scan
// PURPOSE
//  Consumes the four BCD digit counters of the stopwatch and drives a 4-digit
//  multiplexed seven-segment display. Sits directly downstream of the per-digit
//  counter chain. Snapshots all digits once per scan frame so no digit tears
//  mid-frame, rotates the anode, and decodes BCD to segments.
// PARAMETERS
//  REFRESH_DIV  100000  clk_in cycles each digit stays lit (>=2); frame = 4*REFRESH_DIV
//  ACTIVE_LOW   1       1: an/seg/dp asserted low; 0: asserted high
// PORTS
//  clk_in   in   1   system clock
//  reset    in   1   asynchronous, active-high reset
//  digit0   in   4   BCD units digit (rightmost)
//  digit1   in   4   BCD tens digit
//  digit2   in   4   BCD hundreds digit
//  digit3   in   4   BCD thousands digit (leftmost)
//  dp_mask  in   4   decimal-point enable per digit; bit i -> digit i
//  an       out  4   anode enables, one-hot (polarity per ACTIVE_LOW)
//  seg      out  7   segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//  dp       out  1   decimal point for the active digit
// BEHAVIOUR
//  - Reset (async): refresh counter=0, sel=0, snapshot=0, primed=0; an, seg, dp
//    all driven to the inactive level (ACTIVE_LOW=1: an=4'hF, seg=7'h7F, dp=1).
//  - Refresh counter cnt: 0..REFRESH_DIV-1, wraps to 0. When cnt==REFRESH_DIV-1,
//    sel advances 0->1->2->3->0 (2-bit, natural wrap).
//  - Snapshot {digit3..0, dp_mask} is captured on: (a) the first clk_in edge
//    after reset with primed==0 (primed then set to 1), and (b) every edge where
//    cnt==REFRESH_DIV-1 && sel==3 (frame boundary). Never at any other time.
//  - an/seg/dp are registered: each edge loads decode(snapshot[sel_next]) where
//    sel_next is the sel value after that edge. Net effect: an input change is
//    visible no later than the next frame boundary, at which point digit 0 is
//    shown with new data on the same edge that sel returns to 0.
//  - First clk_in edge after reset: an selects digit0 showing the input digit0
//    value present at that edge (snapshot bypassed into decode for that cycle).
//  - an is strictly one-hot active (never two digits lit, never zero lit after
//    the first post-reset edge).
//  - Decode: 0..9 standard patterns (a..g on for 8); inputs 10..15 display a
//    dash (segment g only) -- out-of-range counter values are visible, not hidden.
//  - dp active iff snapshot dp_mask[sel]==1.
//  - Reset asserted mid-frame: outputs go inactive immediately (async), scan
//    restarts at digit 0 with a fresh snapshot on first edge after release.
//  - Inputs are sampled only via the snapshot; they are from the same clk_in
//    domain; no synchronisers.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   defined: when building the snapshot, digit3 blanks if 0; digit2 blanks if
//    0 and digit3 blanked; digit1 blanks if 0 and digit2 blanked. digit0 never
//    blanks. Blanked digit: an still rotates through it, all segments inactive,
//    dp still follows dp_mask.
//   undefined: all four digits always displayed, zeros shown as '0'.
// TESTING  (REFRESH_DIV=4, ACTIVE_LOW=1 unless noted)
//  1 reset held -> an=F, seg=7F, dp=1; release, digits=1,2,3,4 -> first edge an=E,
//    seg='4'; an E->D->B->7->E each 4 cycles with '4','3','2','1'.
//  2 change digit0 4->9 at cycle 5 of frame -> '4' persists on an=E until next
//    frame boundary edge, then an=E with '9'.
//  3 digit2=12 -> that slot shows seg=7'h3F (g only); others unaffected.
//  4 dp_mask=4'b0100 -> dp=0 only while an=B; reset at cycle 7 -> outputs
//    inactive same cycle, scan restarts at an=E.
//  5 LEADING_ZERO_BLANK_EN, digits=0,0,5,0 (d3..d0) -> d3,d2 slots seg=7F,
//    d1='5', d0='0'; all zero -> only d0 shows '0'; without macro all show '0'.
//  6 ACTIVE_LOW=0 -> reset an=0, seg=0, dp=0; digit0 slot an=4'h1, '8'=7'h7F.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
// rtl/stopwatch_display_scan.sv - 4-digit multiplexed seven-segment scanner with per-frame digit snapshot
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros on digits 3..1)
module stopwatch_display_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic [3:0] dp_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_sel;
   logic          r_primed;
   logic [15:0]   r_snap_digits;
   logic [3:0]    r_snap_blank;
   logic [3:0]    r_snap_dp;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic          w_wrap;
   logic          w_capture;
   logic [1:0]    w_sel_next;
   logic [15:0]   w_digits_in;
   logic [3:0]    w_blank_in;
   logic [15:0]   w_snap_digits;
   logic [3:0]    w_snap_blank;
   logic [3:0]    w_snap_dp;
   logic [3:0]    w_cur_digit;
   logic          w_cur_blank;
   logic          w_cur_dp;
   logic [6:0]    w_pattern;
   logic [3:0]    w_onehot;

   assign w_digits_in = {digit3, digit2, digit1, digit0};

`ifdef LEADING_ZERO_BLANK_EN
   logic w_blank3;
   logic w_blank2;
   logic w_blank1;
   assign w_blank3   = (digit3 == 4'd0);
   assign w_blank2   = w_blank3 && (digit2 == 4'd0);
   assign w_blank1   = w_blank2 && (digit1 == 4'd0);
   assign w_blank_in = {w_blank3, w_blank2, w_blank1, 1'b0};
`else
   assign w_blank_in = 4'b0000;
`endif

   assign w_wrap     = (r_cnt == CNT_LAST);
   assign w_capture  = !r_primed || (w_wrap && (r_sel == 2'd3));
   assign w_sel_next = w_wrap ? r_sel + 2'd1 : r_sel;

   // Decode reads the post-edge snapshot so fresh data and the new digit appear on the same edge
   assign w_snap_digits = w_capture ? w_digits_in : r_snap_digits;
   assign w_snap_blank  = w_capture ? w_blank_in  : r_snap_blank;
   assign w_snap_dp     = w_capture ? dp_mask     : r_snap_dp;

   assign w_cur_digit = w_snap_digits[{w_sel_next, 2'b00} +: 4];
   assign w_cur_blank = w_snap_blank[w_sel_next];
   assign w_cur_dp    = w_snap_dp[w_sel_next];
   assign w_onehot    = 4'b0001 << w_sel_next;

   always_comb begin
      w_pattern = 7'b1000000;
      case (w_cur_digit)
         4'd0:    w_pattern = 7'b0111111;
         4'd1:    w_pattern = 7'b0000110;
         4'd2:    w_pattern = 7'b1011011;
         4'd3:    w_pattern = 7'b1001111;
         4'd4:    w_pattern = 7'b1100110;
         4'd5:    w_pattern = 7'b1101101;
         4'd6:    w_pattern = 7'b1111101;
         4'd7:    w_pattern = 7'b0000111;
         4'd8:    w_pattern = 7'b1111111;
         4'd9:    w_pattern = 7'b1101111;
         default: w_pattern = 7'b1000000;
      endcase
      if (w_cur_blank) begin
         w_pattern = 7'b0000000;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_cnt         <= '0;
         r_sel         <= 2'd0;
         r_primed      <= 1'b0;
         r_snap_digits <= 16'h0000;
         r_snap_blank  <= 4'b0000;
         r_snap_dp     <= 4'b0000;
         r_an          <= {4{ACTIVE_LOW}};
         r_seg         <= {7{ACTIVE_LOW}};
         r_dp          <= ACTIVE_LOW;
      end else begin
         r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
         r_sel    <= w_sel_next;
         r_primed <= 1'b1;
         if (w_capture) begin
            r_snap_digits <= w_digits_in;
            r_snap_blank  <= w_blank_in;
            r_snap_dp     <= dp_mask;
         end
         r_an  <= w_onehot ^ {4{ACTIVE_LOW}};
         r_seg <= w_pattern ^ {7{ACTIVE_LOW}};
         r_dp  <= w_cur_dp ^ ACTIVE_LOW;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// tb/tb_stopwatch_display_scan.sv - bench for stopwatch_display_scan (active-low and active-high instances)
// Honours LEADING_ZERO_BLANK_EN when defined.
module tb_stopwatch_display_scan;

   localparam int DIV = 4;

   logic       clk_in = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] digit0 = 4'd4;
   logic [3:0] digit1 = 4'd3;
   logic [3:0] digit2 = 4'd2;
   logic [3:0] digit3 = 4'd1;
   logic [3:0] dp_mask = 4'b0000;

   logic [3:0] an_lo, an_hi;
   logic [6:0] seg_lo, seg_hi;
   logic       dp_lo, dp_hi;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   stopwatch_display_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk_in(clk_in), .reset(reset),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .dp_mask(dp_mask), .an(an_lo), .seg(seg_lo), .dp(dp_lo)
   );

   stopwatch_display_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk_in(clk_in), .reset(reset),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .dp_mask(dp_mask), .an(an_hi), .seg(seg_hi), .dp(dp_hi)
   );

   // Model: t = edges since reset release; slot = (t/DIV)%4; snapshot at t==1 and every 4*DIV edges
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
   int         t = 0;
   logic [3:0] m_dig [4];
   logic [3:0] m_blank;
   logic [3:0] m_dp;

   function automatic logic [3:0] lead_blank(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1);
      logic [3:0] b;
      b = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      b[3] = (d3 == 0);
      b[2] = b[3] && (d2 == 0);
      b[1] = b[2] && (d1 == 0);
`endif
      return b;
   endfunction

   always @(posedge clk_in or posedge reset) begin
      if (reset) begin
         t <= 0;
      end else begin
         t <= t + 1;
         if ((t + 1 == 1) || ((t + 1) % (4 * DIV) == 0)) begin
            m_dig[0] <= digit0;
            m_dig[1] <= digit1;
            m_dig[2] <= digit2;
            m_dig[3] <= digit3;
            m_dp     <= dp_mask;
            m_blank  <= lead_blank(digit3, digit2, digit1);
         end
      end
   end

   task automatic expect_out(input bit al, output logic [3:0] ean, output logic [6:0] eseg,
                             output logic edp);
      int s;
      if (t == 0) begin
         ean  = 4'h0;
         eseg = 7'h00;
         edp  = 1'b0;
      end else begin
         s    = (t / DIV) % 4;
         ean  = 4'(1 << s);
         eseg = m_blank[s] ? 7'h00 : seg_tab[m_dig[s]];
         edp  = m_dp[s];
      end
      if (al) begin
         ean  = ~ean;
         eseg = ~eseg;
         edp  = ~edp;
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
      end
   endtask

   always @(posedge clk_in) begin
      logic [3:0] ean;
      logic [6:0] eseg;
      logic       edp;
      #3;
      expect_out(1'b1, ean, eseg, edp);
      chk("model_an_lo", {4'h0, an_lo}, {4'h0, ean});
      chk("model_seg_lo", {1'b0, seg_lo}, {1'b0, eseg});
      chk("model_dp_lo", {7'h00, dp_lo}, {7'h00, edp});
      expect_out(1'b0, ean, eseg, edp);
      chk("model_an_hi", {4'h0, an_hi}, {4'h0, ean});
      chk("model_seg_hi", {1'b0, seg_hi}, {1'b0, eseg});
      chk("model_dp_hi", {7'h00, dp_hi}, {7'h00, edp});
      if (t != 0) begin
         chk("onehot_hi", 8'($countones(an_hi)), 8'd1);
      end
   end

   // Waits until the model edge count reaches e, landing 3 time units after that edge
   task automatic at_edge(input int e);
      int n;
      n = 0;
      while (t != e && n < 2000) begin
         @(posedge clk_in);
         #3;
         n++;
      end
      checks++;
      if (t != e) begin
         failures++;
         $display("FAIL at_edge_timeout actual=%0d required=%0d", t, e);
      end
   endtask

   task automatic restart();
      @(negedge clk_in);
      reset = 1'b1;
      @(negedge clk_in);
      reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_in);
      #3;
      chk("rst_an_lo", {4'h0, an_lo}, 8'h0F);
      chk("rst_seg_lo", {1'b0, seg_lo}, 8'h7F);
      chk("rst_dp_lo", {7'h00, dp_lo}, 8'h01);
      chk("rst_an_hi", {4'h0, an_hi}, 8'h00);
      chk("rst_seg_hi", {1'b0, seg_hi}, 8'h00);
      chk("rst_dp_hi", {7'h00, dp_hi}, 8'h00);
      @(negedge clk_in);
      reset = 1'b0;

      at_edge(1);  chk("first_an", {4'h0, an_lo}, 8'h0E); chk("first_seg4", {1'b0, seg_lo}, 8'h19);
      at_edge(4);  chk("d1_an", {4'h0, an_lo}, 8'h0D);    chk("d1_seg3", {1'b0, seg_lo}, 8'h30);
      at_edge(8);  chk("d2_an", {4'h0, an_lo}, 8'h0B);    chk("d2_seg2", {1'b0, seg_lo}, 8'h24);
      at_edge(12); chk("d3_an", {4'h0, an_lo}, 8'h07);    chk("d3_seg1", {1'b0, seg_lo}, 8'h79);
      at_edge(16); chk("wrap_an", {4'h0, an_lo}, 8'h0E);  chk("wrap_seg4", {1'b0, seg_lo}, 8'h19);

      @(negedge clk_in);
      digit0 = 4'd9;
      at_edge(17); chk("hold_seg4", {1'b0, seg_lo}, 8'h19);
      at_edge(31); chk("hold_d3_an", {4'h0, an_lo}, 8'h07);
      at_edge(32); chk("new_an", {4'h0, an_lo}, 8'h0E);   chk("new_seg9", {1'b0, seg_lo}, 8'h10);

      @(negedge clk_in);
      digit2 = 4'd12;
      at_edge(40); chk("old_d2_seg", {1'b0, seg_lo}, 8'h24);
      at_edge(56); chk("dash_an", {4'h0, an_lo}, 8'h0B);  chk("dash_seg", {1'b0, seg_lo}, 8'h3F);
      at_edge(60); chk("after_dash", {1'b0, seg_lo}, 8'h79);

      @(negedge clk_in);
      dp_mask = 4'b0100;
      at_edge(64); chk("dp_off_d0", {7'h00, dp_lo}, 8'h01);
      at_edge(72); chk("dp_on_an", {4'h0, an_lo}, 8'h0B); chk("dp_on_d2", {7'h00, dp_lo}, 8'h00);
      at_edge(76); chk("dp_off_d3", {7'h00, dp_lo}, 8'h01);

      at_edge(86);
      @(negedge clk_in);
      reset = 1'b1;
      #1;
      chk("async_an_lo", {4'h0, an_lo}, 8'h0F);
      chk("async_seg_lo", {1'b0, seg_lo}, 8'h7F);
      chk("async_dp_lo", {7'h00, dp_lo}, 8'h01);
      chk("async_an_hi", {4'h0, an_hi}, 8'h00);
      digit0  = 4'd8;
      dp_mask = 4'b0001;
      @(negedge clk_in);
      reset = 1'b0;
      at_edge(1);
      chk("restart_an", {4'h0, an_lo}, 8'h0E);
      chk("restart_seg8", {1'b0, seg_lo}, 8'h00);
      chk("hi_an", {4'h0, an_hi}, 8'h01);
      chk("hi_seg8", {1'b0, seg_hi}, 8'h7F);
      chk("hi_dp", {7'h00, dp_hi}, 8'h01);

      @(negedge clk_in);
      digit3 = 4'd0; digit2 = 4'd0; digit1 = 4'd5; digit0 = 4'd0; dp_mask = 4'b1000;
      restart();
      at_edge(1);  chk("lz_d0", {1'b0, seg_lo}, 8'h40);
      at_edge(4);  chk("lz_d1", {1'b0, seg_lo}, 8'h12);
`ifdef LEADING_ZERO_BLANK_EN
      at_edge(8);  chk("lz_d2", {1'b0, seg_lo}, 8'h7F);
      at_edge(12); chk("lz_d3", {1'b0, seg_lo}, 8'h7F); chk("lz_d3_dp", {7'h00, dp_lo}, 8'h00);
`else
      at_edge(8);  chk("lz_d2", {1'b0, seg_lo}, 8'h40);
      at_edge(12); chk("lz_d3", {1'b0, seg_lo}, 8'h40); chk("lz_d3_dp", {7'h00, dp_lo}, 8'h00);
`endif
      @(negedge clk_in);
      digit1 = 4'd0;
      at_edge(16); chk("zero_d0", {1'b0, seg_lo}, 8'h40);
`ifdef LEADING_ZERO_BLANK_EN
      at_edge(20); chk("zero_d1", {1'b0, seg_lo}, 8'h7F);
`else
      at_edge(20); chk("zero_d1", {1'b0, seg_lo}, 8'h40);
`endif
      at_edge(24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
